// File: rtl/if_id_latch.sv
// Fetch/decode pipeline register with a one-entry skid buffer for fetches returned during a stall.
// Define IF_ID_PERF_EN to add saturating STALL/FLUSH cycle counters.

package if_id_pkg;
    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        STALL  = 2'd1,
        FLUSH  = 2'd2
    } pipe_state_t;
endpackage

module if_id_latch
    import if_id_pkg::*;
#(
    parameter int          WORD_W   = 32,
    parameter logic [31:0] NOP_WORD = 32'h00000000,
    parameter int          CNT_W    = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  pipe_state_t       fd_state,
    input  logic              ihit,
    input  logic [WORD_W-1:0] imemload,
    input  logic [WORD_W-1:0] npc_in,
    output logic [WORD_W-1:0] instr_out,
    output logic [WORD_W-1:0] npc_out,
    output logic              valid_out,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic              skid_full,
    output logic              proto_err,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } skid_state_t;

    skid_state_t       skid_state;
    logic [WORD_W-1:0] skid_instr;
    logic [WORD_W-1:0] skid_npc;
    logic [WORD_W-1:0] out_instr;
    logic [WORD_W-1:0] out_npc;
    logic              out_valid;
    logic              proto_err_q;
    logic              is_stall;
    logic              skid_load;

    // Anything that is neither NORMAL nor FLUSH behaves as STALL.
    assign is_stall  = (fd_state != NORMAL) && (fd_state != FLUSH);

    // Skid captures the fetch when draining while a new word arrives, or when stalled and empty.
    assign skid_load = ihit && (((fd_state == NORMAL) && (skid_state == HELD)) ||
                                (is_stall && (skid_state == EMPTY)));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            skid_state  <= EMPTY;
            out_instr   <= NOP_WORD[WORD_W-1:0];
            out_npc     <= '0;
            out_valid   <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            proto_err_q <= 1'b0;
            case (fd_state)
                NORMAL: begin
                    if (skid_state == HELD) begin
                        out_instr  <= skid_instr;
                        out_npc    <= skid_npc;
                        out_valid  <= 1'b1;
                        skid_state <= ihit ? HELD : EMPTY;
                    end else if (ihit) begin
                        out_instr <= imemload;
                        out_npc   <= npc_in;
                        out_valid <= 1'b1;
                    end else begin
                        out_instr <= NOP_WORD[WORD_W-1:0];
                        out_valid <= 1'b0;
                    end
                end
                FLUSH: begin
                    out_instr  <= NOP_WORD[WORD_W-1:0];
                    out_valid  <= 1'b0;
                    skid_state <= EMPTY;
                end
                default: begin
                    if (ihit) begin
                        if (skid_state == EMPTY) begin
                            skid_state <= HELD;
                        end else begin
                            proto_err_q <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // NOTE: skid payload has no reset; skid_state alone decides whether it is meaningful.
    always_ff @(posedge CLK) begin
        if (skid_load) begin
            skid_instr <= imemload;
            skid_npc   <= npc_in;
        end
    end

    assign instr_out = out_instr;
    assign npc_out   = out_npc;
    assign valid_out = out_valid;
    assign skid_full = (skid_state == HELD);
    assign proto_err = proto_err_q;

    // Bubbles present register 0 so they never alias a real writeback destination.
    assign rs = out_valid ? out_instr[25:21] : 5'd0;
    assign rt = out_valid ? out_instr[20:16] : 5'd0;

`ifdef IF_ID_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (is_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if ((fd_state == FLUSH) && (flush_cnt_q != {CNT_W{1'b1}})) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif

endmodule
